// File: rtl/maze_pkg.sv
// rtl/maze_pkg.sv - shared types and constants for the maze memory arbiter
// Purpose: default index width, arbiter FSM state encoding and requester ids.
package maze_pkg;

  localparam int MAZE_WIDTH = 6;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_READ  = 2'd2
  } state_e;

  localparam logic REQ_SOLVER = 1'b0;
  localparam logic REQ_HOST   = 1'b1;

endpackage

// File: rtl/rr_arbiter2.sv
// rtl/rr_arbiter2.sv - two-way round-robin winner selection
// Purpose: purely combinational pick between two requesters.
// Ports:
//   req_i      [1:0] request vector, bit k = requester k
//   last_gnt_i       id of the requester granted most recently
//   gnt_o      [1:0] one-hot winner, all zero when nobody requests
module rr_arbiter2
  import maze_pkg::*;
(
  input  logic [1:0] req_i,
  input  logic       last_gnt_i,
  output logic [1:0] gnt_o
);

  always_comb begin
    gnt_o = 2'b00;
    case (req_i)
      2'b01:   gnt_o = 2'b01;
      2'b10:   gnt_o = 2'b10;
      // On contention the requester that was not served last time wins.
      2'b11:   gnt_o = (last_gnt_i == REQ_HOST) ? 2'b01 : 2'b10;
      default: gnt_o = 2'b00;
    endcase
  end

endmodule

// File: rtl/maze_mem_arbiter.sv
// rtl/maze_mem_arbiter.sv - shares the single maze memory port between two requesters
// Purpose: round-robin arbitration of single-cell read/write commands from the
// wall-following solver (requester 0) and the loader/scanner (requester 1).
// Ports:
//   clk, rst_n                 clock, asynchronous active-low reset
//   req{0,1}_i, we{0,1}_i      command request and write flag, held with req
//   row{0,1}_i, col{0,1}_i     cell address of each requester
//   gnt{0,1}_o                 one-cycle command-accepted pulse
//   rvalid{0,1}_o, rdata{0,1}_o read data return, rdata held until next read
//   row_o, col_o               registered memory address
//   maze_oe_o, maze_we_o       registered one-cycle read / write enables
//   maze_in_i                  memory read data, valid the cycle after maze_oe
module maze_mem_arbiter
  import maze_pkg::*;
#(
  parameter int maze_width = MAZE_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  req0_i,
  input  logic                  we0_i,
  input  logic [maze_width-1:0] row0_i,
  input  logic [maze_width-1:0] col0_i,
  input  logic                  req1_i,
  input  logic                  we1_i,
  input  logic [maze_width-1:0] row1_i,
  input  logic [maze_width-1:0] col1_i,
  output logic                  gnt0_o,
  output logic                  gnt1_o,
  output logic                  rvalid0_o,
  output logic                  rvalid1_o,
  output logic                  rdata0_o,
  output logic                  rdata1_o,
  output logic [maze_width-1:0] row_o,
  output logic [maze_width-1:0] col_o,
  output logic                  maze_oe_o,
  output logic                  maze_we_o,
  input  logic                  maze_in_i
);

  state_e                state_q, state_d;
  logic                  last_gnt_q, last_gnt_d;
  logic [maze_width-1:0] row_q, row_d;
  logic [maze_width-1:0] col_q, col_d;
  logic                  oe_q, oe_d;
  logic                  we_q, we_d;
  logic                  gnt0_q, gnt0_d;
  logic                  gnt1_q, gnt1_d;
  logic                  rvalid0_q, rvalid0_d;
  logic                  rvalid1_q, rvalid1_d;
  logic                  rdata0_q, rdata0_d;
  logic                  rdata1_q, rdata1_d;
  logic [1:0]            win;

  rr_arbiter2 u_arb (
    .req_i      ({req1_i, req0_i}),
    .last_gnt_i (last_gnt_q),
    .gnt_o      (win)
  );

  always_comb begin
    state_d    = state_q;
    last_gnt_d = last_gnt_q;
    row_d      = row_q;
    col_d      = col_q;
    oe_d       = 1'b0;
    we_d       = 1'b0;
    gnt0_d     = 1'b0;
    gnt1_d     = 1'b0;
    rvalid0_d  = 1'b0;
    rvalid1_d  = 1'b0;
    rdata0_d   = rdata0_q;
    rdata1_d   = rdata1_q;

    case (state_q)
      ST_IDLE: begin
        if (win[0]) begin
          row_d      = row0_i;
          col_d      = col0_i;
          oe_d       = ~we0_i;
          we_d       = we0_i;
          gnt0_d     = 1'b1;
          last_gnt_d = REQ_SOLVER;
          state_d    = ST_ISSUE;
        end else if (win[1]) begin
          row_d      = row1_i;
          col_d      = col1_i;
          oe_d       = ~we1_i;
          we_d       = we1_i;
          gnt1_d     = 1'b1;
          last_gnt_d = REQ_HOST;
          state_d    = ST_ISSUE;
        end
      end
      // The registered command is on the memory port during this state.
      ST_ISSUE: state_d = we_q ? ST_IDLE : ST_READ;
      // last_gnt still names the owner of the read in flight.
      ST_READ: begin
        if (last_gnt_q == REQ_SOLVER) begin
          rdata0_d  = maze_in_i;
          rvalid0_d = 1'b1;
        end else begin
          rdata1_d  = maze_in_i;
          rvalid1_d = 1'b1;
        end
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      last_gnt_q <= REQ_HOST;
      row_q      <= '0;
      col_q      <= '0;
      oe_q       <= 1'b0;
      we_q       <= 1'b0;
      gnt0_q     <= 1'b0;
      gnt1_q     <= 1'b0;
      rvalid0_q  <= 1'b0;
      rvalid1_q  <= 1'b0;
      rdata0_q   <= 1'b0;
      rdata1_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      last_gnt_q <= last_gnt_d;
      row_q      <= row_d;
      col_q      <= col_d;
      oe_q       <= oe_d;
      we_q       <= we_d;
      gnt0_q     <= gnt0_d;
      gnt1_q     <= gnt1_d;
      rvalid0_q  <= rvalid0_d;
      rvalid1_q  <= rvalid1_d;
      rdata0_q   <= rdata0_d;
      rdata1_q   <= rdata1_d;
    end
  end

  assign gnt0_o    = gnt0_q;
  assign gnt1_o    = gnt1_q;
  assign rvalid0_o = rvalid0_q;
  assign rvalid1_o = rvalid1_q;
  assign rdata0_o  = rdata0_q;
  assign rdata1_o  = rdata1_q;
  assign row_o     = row_q;
  assign col_o     = col_q;
  assign maze_oe_o = oe_q;
  assign maze_we_o = we_q;

endmodule

// File: tb/tb_maze_mem_arbiter.sv
// tb/tb_maze_mem_arbiter.sv - self-checking bench for maze_mem_arbiter
module tb_maze_mem_arbiter;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       req0, we0, req1, we1, maze_in;
  logic [5:0] row0, col0, row1, col1;
  logic       gnt0, gnt1, rvalid0, rvalid1, rdata0, rdata1, maze_oe, maze_we;
  logic [5:0] row, col;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  maze_mem_arbiter #(.maze_width(6)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req0_i    (req0),
    .we0_i     (we0),
    .row0_i    (row0),
    .col0_i    (col0),
    .req1_i    (req1),
    .we1_i     (we1),
    .row1_i    (row1),
    .col1_i    (col1),
    .gnt0_o    (gnt0),
    .gnt1_o    (gnt1),
    .rvalid0_o (rvalid0),
    .rvalid1_o (rvalid1),
    .rdata0_o  (rdata0),
    .rdata1_o  (rdata1),
    .row_o     (row),
    .col_o     (col),
    .maze_oe_o (maze_oe),
    .maze_we_o (maze_we),
    .maze_in_i (maze_in)
  );

  typedef struct {
    logic       rst_n;
    logic       req0, we0;
    logic [5:0] row0, col0;
    logic       req1, we1;
    logic [5:0] row1, col1;
    logic       maze_in;
    logic [19:0] exp;
  } vec_t;

  vec_t vecs[13];

  // Expected output bundle: {gnt0,gnt1,rvalid0,rvalid1,rdata0,rdata1,row,col,oe,we}
  function automatic logic [19:0] mk(input logic g0, input logic g1, input logic v0,
                                     input logic v1, input logic d0, input logic d1,
                                     input logic [5:0] r, input logic [5:0] c,
                                     input logic oe, input logic we);
    return {g0, g1, v0, v1, d0, d1, r, c, oe, we};
  endfunction

  function automatic logic [19:0] actual();
    return {gnt0, gnt1, rvalid0, rvalid1, rdata0, rdata1, row, col, maze_oe, maze_we};
  endfunction

  // Memory model: a cell is a wall when row and column parities differ.
  function automatic logic mem(input logic [5:0] r, input logic [5:0] c);
    return r[0] ^ c[0];
  endfunction

  task automatic check(input string name, input logic [19:0] exp);
    total++;
    if (actual() !== exp) begin
      bad++;
      $display("FAIL %s: got g0g1v0v1d0d1=%b row=%0d col=%0d oe=%b we=%b, want g0g1v0v1d0d1=%b row=%0d col=%0d oe=%b we=%b",
               name, actual()[19:14], actual()[13:8], actual()[7:2], actual()[1], actual()[0],
               exp[19:14], exp[13:8], exp[7:2], exp[1], exp[0]);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    req0 = 0; we0 = 0; row0 = 0; col0 = 0;
    req1 = 0; we1 = 0; row1 = 0; col1 = 0;
    maze_in = 0;
  endtask

  task automatic do_reset();
    clear_inputs();
    rst_n = 0;
    step();
    step();
    rst_n = 1;
    step();
  endtask

  initial begin
    rst_n = 0;
    clear_inputs();

    // rst, req0, we0, row0, col0, req1, we1, row1, col1, maze_in, expected
    vecs[0]  = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0, mk(0,0,0,0,0,0, 0, 0,0,0)};
    vecs[1]  = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0, mk(0,0,0,0,0,0, 0, 0,0,0)};
    vecs[2]  = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0, mk(0,0,0,0,0,0, 0, 0,0,0)};
    vecs[3]  = '{1, 0, 0, 0, 0, 0, 0, 0, 0, 0, mk(0,0,0,0,0,0, 0, 0,0,0)};
    vecs[4]  = '{1, 1, 0, 5, 9, 0, 0, 0, 0, 0, mk(1,0,0,0,0,0, 5, 9,1,0)};
    vecs[5]  = '{1, 0, 0, 0, 0, 0, 0, 0, 0, 0, mk(0,0,0,0,0,0, 5, 9,0,0)};
    vecs[6]  = '{1, 0, 0, 0, 0, 0, 0, 0, 0, 1, mk(0,0,1,0,1,0, 5, 9,0,0)};
    vecs[7]  = '{1, 0, 0, 0, 0, 0, 0, 0, 0, 0, mk(0,0,0,0,1,0, 5, 9,0,0)};
    vecs[8]  = '{1, 0, 0, 0, 0, 1, 1,63, 0, 0, mk(0,1,0,0,1,0,63, 0,0,1)};
    vecs[9]  = '{1, 0, 0, 0, 0, 0, 0, 0, 0, 1, mk(0,0,0,0,1,0,63, 0,0,0)};
    vecs[10] = '{1, 1, 0, 1, 2, 0, 0, 0, 0, 1, mk(1,0,0,0,1,0, 1, 2,1,0)};
    vecs[11] = '{1, 0, 0, 0, 0, 0, 0, 0, 0, 1, mk(0,0,0,0,1,0, 1, 2,0,0)};
    vecs[12] = '{1, 0, 0, 0, 0, 0, 0, 0, 0, 0, mk(0,0,1,0,0,0, 1, 2,0,0)};

    #1;
    for (int i = 0; i < 13; i++) begin
      rst_n   = vecs[i].rst_n;
      req0    = vecs[i].req0;    we0 = vecs[i].we0;
      row0    = vecs[i].row0;    col0 = vecs[i].col0;
      req1    = vecs[i].req1;    we1 = vecs[i].we1;
      row1    = vecs[i].row1;    col1 = vecs[i].col1;
      maze_in = vecs[i].maze_in;
      step();
      check($sformatf("vec%0d", i), vecs[i].exp);
    end

    // Contention: both read continuously, grants alternate starting with 0.
    do_reset();
    req0 = 1; we0 = 0; row0 = 10; col0 = 11;
    req1 = 1; we1 = 0; row1 = 21; col1 = 20;
    for (int s = 0; s < 12; s++) begin
      int ph;
      ph = s % 6;
      maze_in = mem(row, col);
      step();
      check($sformatf("contend%0d", s),
            mk(ph == 0, ph == 3, ph == 2, ph == 5, s >= 2, s >= 5,
               (ph < 3) ? 6'd10 : 6'd21, (ph < 3) ? 6'd11 : 6'd20,
               ph == 0 || ph == 3, 0));
    end
    clear_inputs();

    // Back-to-back writes from requester 0: one write every 2 cycles.
    do_reset();
    req0 = 1; we0 = 1; row0 = 7; col0 = 8;
    for (int s = 0; s < 8; s++) begin
      step();
      check($sformatf("b2b_wr%0d", s), mk(s % 2 == 0, 0, 0, 0, 0, 0, 7, 8, 0, s % 2 == 0));
    end
    clear_inputs();

    // Stale request: req0 still high in the IDLE after a write grant.
    do_reset();
    we0 = 1; row0 = 3; col0 = 4;
    for (int s = 0; s < 5; s++) begin
      req0 = (s <= 2);
      step();
      check($sformatf("stale%0d", s), mk(s == 0 || s == 2, 0, 0, 0, 0, 0, 3, 4, 0, s == 0 || s == 2));
    end
    clear_inputs();

    // Reset in the middle of a read from requester 0.
    do_reset();
    req0 = 1; we0 = 0; row0 = 33; col0 = 44;
    step();
    check("midrst_gnt", mk(1,0,0,0,0,0,33,44,1,0));
    req0 = 0;
    step();
    maze_in = 1;
    rst_n = 0;
    #1;
    check("midrst_async", mk(0,0,0,0,0,0,0,0,0,0));
    step();
    check("midrst_held", mk(0,0,0,0,0,0,0,0,0,0));
    rst_n = 1;
    step();
    check("midrst_no_rvalid", mk(0,0,0,0,0,0,0,0,0,0));
    req0 = 1; req1 = 1; row1 = 2; col1 = 3;
    step();
    check("midrst_prio", mk(1,0,0,0,0,0,33,44,1,0));
    clear_inputs();
    step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/maze_mem_arbiter.md
# maze_mem_arbiter

Shares the single maze memory port (row/col select, maze_oe, maze_we, 1-bit maze_in) between two requesters: requester 0 is the wall-following solver and requester 1 is the maze loader/display scanner. Each requester issues single read or write commands with a req/gnt handshake. The arbiter picks a winner round-robin, drives the registered memory command for one cycle, and returns read data with an rvalid pulse. It sits between the requesters and the maze storage.

## Interface
- maze_width, default 6: bit width of row and column indices.
- clk  in  1  system clock; everything is rising-edge.
- rst_n  in  1  reset; one clock, asynchronous and active-low.
- req0 / req1  in  1  command request from requester 0 / 1.
- we0 / we1  in  1  1 = write (mark cell), 0 = read; held with req.
- row0, col0 / row1, col1  in  maze_width  cell address; held with req.
- gnt0 / gnt1  out  1  one-cycle pulse: command accepted.
- rvalid0 / rvalid1  out  1  one-cycle pulse: read data valid.
- rdata0 / rdata1  out  1  read data, valid only while the matching rvalid is high.
- row, col  out  maze_width  memory address, registered.
- maze_oe  out  1  memory read enable, registered, one cycle wide.
- maze_we  out  1  memory write enable, registered, one cycle wide.
- maze_in  in  1  memory read data, valid in the cycle after maze_oe.

## Operation
- The FSM has three states: IDLE, ISSUE, READ.
- IDLE:
  - req0/req1 are sampled only in this state.
  - If neither is high, stay in IDLE.
  - If exactly one is high, that requester wins.
  - If both are high, the requester not granted last time wins. After reset, priority goes to requester 0.
  - On a win: load row/col from the winner, set maze_oe = ~we and maze_we = we, set the matching gnt, record the winner in last_gnt, and go to ISSUE.
- ISSUE:
  - The command and gnt are visible for exactly this one cycle.
  - Write: go to IDLE.
  - Read: go to READ.
- READ:
  - maze_in is valid in this cycle.
  - Register rdata_k <= maze_in and set rvalid_k, so rvalid is high in the following IDLE cycle.
  - Go to IDLE.
- In every other cycle, maze_oe, maze_we, gnt0/1 and rvalid0/1 are 0.
- row/col hold their last value when no command is active.
- rdata_k holds its value until that requester's next read.
- Requester rule: the cycle after gnt, req must be deasserted or carry a new command. A req still high at that point is treated as a new request.
- The non-winning requester keeps req asserted. It is guaranteed service at the next IDLE, so the worst-case wait is one foreign transaction (3 cycles).
- Address arithmetic is pass-through. There is no range check; the all-ones index is legal.
- Reset mid-operation (rst_n low in any state):
  - Immediately go to IDLE.
  - All outputs go to 0: row = col = 0, maze_oe = maze_we = 0, gnt = rvalid = rdata = 0.
  - last_gnt goes to requester 1, so requester 0 has priority next.
  - An in-flight read produces no rvalid.

## Timing
- Request sampled in IDLE at cycle T:
  - gnt and the memory command appear in T+1.
  - Read data is on maze_in in T+2.
  - rvalid/rdata appear in T+3.
- Read throughput: one read per 3 cycles. Write throughput: one write per 2 cycles.
- Back-to-back: a new request can be sampled in T+2 (after a write) or T+3 (after a read).
- All outputs are registered. There is no combinational path from req/maze_in to any output.

## Structure
- Shared package maze_pkg holds:
  - the MAZE_WIDTH default (6);
  - the state encoding (IDLE = 0, ISSUE = 1, READ = 2), 2 bits;
  - requester ids (REQ_SOLVER = 0, REQ_HOST = 1).
- Sub-module rr_arbiter2 (combinational): takes req[1:0] and last_gnt and returns a one-hot winner. The top module keeps the FSM, the last_gnt register and the output registers.

## Test plan
- Reset values: hold rst_n low 3 cycles, then release -> all outputs 0. Then req0 = 1, we0 = 0, row0 = 5, col0 = 9 -> gnt0, row = 5, col = 9 and maze_oe = 1 one cycle later; drive maze_in = 1 the next cycle; rvalid0 = 1 and rdata0 = 1 on the following cycle.
- Single write: req1 = 1, we1 = 1, row1 = 63, col1 = 0 -> gnt1 and maze_we = 1 with row = 63, col = 0; no rvalid1; IDLE again 2 cycles after sampling.
- Contention: req0 and req1 both held high continuously, all reads -> grants alternate 0,1,0,1 after reset. Each rvalid matches its own requester and address, 3 cycles apart.
- Back-to-back writes from requester 0 only -> gnt0 every 2 cycles; maze_we is never high in two consecutive cycles.
- Reset mid-read: assert rst_n low during READ -> outputs 0 immediately; no rvalid after release. With req0 and req1 both high after release, requester 0 is granted first.
- Stale request: requester keeps req0 high the cycle after gnt0 -> treated as a second command; a second gnt0 appears.
